s_decode_stage: RTL and testbench

S_DECODE_STAGE -- requirements
Module: s_decode_stage

---
 rtl/s_decode_pkg.sv | 60 ++++++
 rtl/s_decode_stage_bypass.sv | 46 ++++
 rtl/s_decode_stage.sv | 140 ++++++++++++++
 tb/tb_s_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_decode_pkg.sv
// Shared types and instruction-decode helpers for the decode stage.
// Opcode/funct constants cover only the fields the stage inspects.
package s_decode_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      READ  = 2'd1,
      ISSUE = 2'd2
   } dec_state_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_MULT   = 6'h18;
   localparam logic [5:0] FN_DIVU   = 6'h1B;

   localparam logic [4:0] REG_RA    = 5'd31;

   // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
   function automatic logic [31:0] decode_imm(input logic [31:0] instr);
      logic [5:0] op;
      op = instr[31:26];
      if (op >= OP_ANDI && op <= OP_XORI)
         return {16'h0000, instr[15:0]};
      return {{16{instr[15]}}, instr[15:0]};
   endfunction

   function automatic logic [4:0] decode_dest(input logic [31:0] instr);
      logic [4:0] dest;
      case (instr[31:26])
         OP_RTYPE: dest = instr[15:11];
         OP_JAL:   dest = REG_RA;
         default:  dest = instr[20:16];
      endcase
      return dest;
   endfunction

   function automatic logic decode_reg_write(input logic [31:0] instr);
      logic [5:0] op;
      logic [5:0] fn;
      logic       no_write;
      op = instr[31:26];
      fn = instr[5:0];
      no_write = (op == OP_REGIMM) || (op == OP_J)
              || (op >= OP_BEQ && op <= OP_BGTZ)
              || (op >= OP_SB && op <= OP_SW)
              || (op == OP_RTYPE && (fn == FN_JR || (fn >= FN_MULT && fn <= FN_DIVU)));
      return !no_write && (decode_dest(instr) != 5'd0);
   endfunction

endpackage

// File: rtl/s_decode_stage_bypass.sv
// Per-operand writeback bypass: override register, address match and output mux.
// Once in ISSUE the register-file value is also captured so a stalled operand stays put.
module s_operand_bypass
   import s_decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clear,
   input  logic        track,
   input  logic        load_rf,
   input  logic [4:0]  addr,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic [31:0] rf_data,
   output logic [31:0] operand
);

   logic        ovr_valid;
   logic [31:0] ovr_data;
   logic        match;

   assign match = track && wb_we && (wb_addr == addr) && (addr != 5'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovr_valid <= 1'b0;
         ovr_data  <= '0;
      end else if (en) begin
         if (clear) begin
            ovr_valid <= 1'b0;
            ovr_data  <= '0;
         end else if (match) begin
            ovr_valid <= 1'b1;
            ovr_data  <= wb_data;
         end else if (load_rf && !ovr_valid) begin
            ovr_valid <= 1'b1;
            ovr_data  <= rf_data;
         end
      end
   end

   assign operand = (addr == 5'd0) ? 32'h0 : (ovr_valid ? ovr_data : rf_data);

endmodule

// File: rtl/s_decode_stage.sv
// Decode stage: holds one fetched instruction, reads its operands, and issues
// the decoded fields to execute with a valid/ready handshake.
//
//   state | meaning
//   EMPTY | no instruction held; ready to accept from fetch
//   READ  | register-file read in flight for the held instruction
//   ISSUE | decoded instruction presented to execute, waiting for ex_ready
module s_decode_stage
   import s_decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        if_valid,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic        id_ready,
   input  logic        flush,
   output logic        rf_rd,
   output logic [4:0]  rf_read_address_1,
   output logic [4:0]  rf_read_address_2,
   input  logic [31:0] rf_read_data_1,
   input  logic [31:0] rf_read_data_2,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [31:0] ex_rs_data,
   output logic [31:0] ex_rt_data,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_pc,
   output logic [5:0]  ex_opcode,
   output logic [5:0]  ex_funct,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_write
);

   dec_state_t  state, state_d;
   logic [31:0] instr_q, pc_q;
   logic        load, clear_ovr, track, load_rf;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= EMPTY;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (en) begin
         state <= state_d;
         if (load) begin
            instr_q <= if_instr;
            pc_q    <= if_pc;
         end
      end
   end

   always_comb begin
      state_d   = state;
      load      = 1'b0;
      clear_ovr = 1'b0;
      if (en) begin
         if (flush) begin
            state_d   = EMPTY;
            clear_ovr = 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  if (if_valid) begin
                     load    = 1'b1;
                     state_d = READ;
                  end
               end
               READ: state_d = ISSUE;
               ISSUE: begin
                  if (ex_ready) begin
                     clear_ovr = 1'b1;
                     if (if_valid) begin
                        load    = 1'b1;
                        state_d = READ;
                     end else begin
                        state_d = EMPTY;
                     end
                  end
               end
               default: state_d = EMPTY;
            endcase
         end
      end
   end

   // Ready is withheld during a flush so fetch never sees a dropped handshake.
   assign id_ready = rst && en && !flush
                  && ((state == EMPTY) || ((state == ISSUE) && ex_ready));
   assign rf_rd    = rst && en && (state == READ);
   assign ex_valid = rst && (state == ISSUE);

   assign rf_read_address_1 = instr_q[25:21];
   assign rf_read_address_2 = instr_q[20:16];

   assign track   = (state == READ) || (state == ISSUE);
   assign load_rf = (state == ISSUE);

   s_operand_bypass u_bypass_rs (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear   (clear_ovr),
      .track   (track),
      .load_rf (load_rf),
      .addr    (instr_q[25:21]),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rf_data (rf_read_data_1),
      .operand (ex_rs_data)
   );

   s_operand_bypass u_bypass_rt (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear   (clear_ovr),
      .track   (track),
      .load_rf (load_rf),
      .addr    (instr_q[20:16]),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rf_data (rf_read_data_2),
      .operand (ex_rt_data)
   );

   assign ex_opcode    = instr_q[31:26];
   assign ex_funct     = instr_q[5:0];
   assign ex_pc        = pc_q;
   assign ex_imm       = decode_imm(instr_q);
   assign ex_dest      = decode_dest(instr_q);
   assign ex_reg_write = decode_reg_write(instr_q);

endmodule

// File: tb/tb_s_decode_stage.sv
// Bench for s_decode_stage: directed multi-cycle sequences plus a decode vector
// table checked through an expected-result queue against a behavioural register file.
module tb_s_decode_stage;

   logic        clk = 1'b0;
   logic        rst, en, if_valid, flush, wb_we, ex_ready;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_addr;
   logic        id_ready, rf_rd, ex_valid, ex_reg_write;
   logic [4:0]  rf_read_address_1, rf_read_address_2, ex_dest;
   logic [31:0] rf_read_data_1, rf_read_data_2;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
   logic [5:0]  ex_opcode, ex_funct;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] I_ADD  = 32'h012A4020;
   localparam logic [31:0] I_ORI  = 32'h3422FFFF;
   localparam logic [31:0] I_ANDI = 32'h3085F0F0;
   localparam logic [31:0] I_SLTI = 32'h2886FFF0;

   always #5 clk = ~clk;

   s_decode_stage dut (
      .clk(clk), .rst(rst), .en(en),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
      .flush(flush), .rf_rd(rf_rd),
      .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
      .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write)
   );

   // Register file: read data registered on rf_rd, old value on same-edge write.
   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hBAD0BAD0;
      return 32'hA0000000 | (32'(i) << 8) | 32'(i);
   endfunction

   logic [31:0] rf [32];
   logic        rf_load;

   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      end else if (wb_we) begin
         rf[wb_addr] <= wb_data;
      end
      if (rf_rd) begin
         rf_read_data_1 <= rf[rf_read_address_1];
         rf_read_data_2 <= rf[rf_read_address_2];
      end
   end

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        rw;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        rw;
      logic [31:0] rs;
      logic [31:0] rt;
   } exp_t;

   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after inputs settle: pops and compares when a transfer will occur at the next edge.
   task automatic sb_pop();
      exp_t e;
      if (ex_valid && ex_ready && en) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got transfer pc %h expected none", ex_pc);
         end else begin
            e = sb_q.pop_front();
            chk("tbl_rs",     ex_rs_data,          e.rs);
            chk("tbl_rt",     ex_rt_data,          e.rt);
            chk("tbl_imm",    ex_imm,              e.imm);
            chk("tbl_pc",     ex_pc,               e.pc);
            chk("tbl_opcode", 32'(ex_opcode),      32'(e.instr[31:26]));
            chk("tbl_funct",  32'(ex_funct),       32'(e.instr[5:0]));
            chk("tbl_dest",   32'(ex_dest),        32'(e.dest));
            chk("tbl_rw",     32'(ex_reg_write),   32'(e.rw));
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; rf_load = 1'b1; en = 1'b1; flush = 1'b0;
      if_valid = 1'b0; if_instr = '0; if_pc = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b0;
      #1 chk("rst_id_ready_low", 32'(id_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1; rf_load = 1'b0;
   endtask

   vec_t vecs [13];

   initial begin
      exp_t e;
      int   accepted;

      vecs[0]  = '{32'h012A4020, 32'h00004020, 5'd8,  1'b1};  // add
      vecs[1]  = '{32'h8C200004, 32'h00000004, 5'd0,  1'b0};  // lw $0
      vecs[2]  = '{32'h3422FFFF, 32'h0000FFFF, 5'd2,  1'b1};  // ori
      vecs[3]  = '{32'h2022FFFF, 32'hFFFFFFFF, 5'd2,  1'b1};  // addi
      vecs[4]  = '{32'hAC430008, 32'h00000008, 5'd3,  1'b0};  // sw
      vecs[5]  = '{32'h10430010, 32'h00000010, 5'd3,  1'b0};  // beq
      vecs[6]  = '{32'h0C000040, 32'h00000040, 5'd31, 1'b1};  // jal
      vecs[7]  = '{32'h03E00008, 32'h00000008, 5'd0,  1'b0};  // jr
      vecs[8]  = '{32'h00853018, 32'h00003018, 5'd6,  1'b0};  // mult with rd!=0
      vecs[9]  = '{32'h3085F0F0, 32'h0000F0F0, 5'd5,  1'b1};  // andi
      vecs[10] = '{32'h2886FFF0, 32'hFFFFFFF0, 5'd6,  1'b1};  // slti
      vecs[11] = '{32'h38A78001, 32'h00008001, 5'd7,  1'b1};  // xori
      vecs[12] = '{32'h3C088000, 32'hFFFF8000, 5'd8,  1'b1};  // lui

      // Reset state and basic accept -> read -> issue with a READ-cycle bypass.
      do_reset();
      #1;
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_id_ready", 32'(id_ready), 32'd1);
      chk("reset_rf_rd",    32'(rf_rd),    32'd0);
      chk("reset_ex_pc",    ex_pc,         32'd0);
      chk("reset_ex_dest",  32'(ex_dest),  32'd0);

      if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h200;
      #1 chk("a_accept_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
      #1;
      chk("a_rf_rd",     32'(rf_rd),             32'd1);
      chk("a_rd_addr1",  32'(rf_read_address_1), 32'd9);
      chk("a_rd_addr2",  32'(rf_read_address_2), 32'd10);
      chk("a_read_busy", 32'(id_ready),          32'd0);
      chk("a_read_nval", 32'(ex_valid),          32'd0);
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      chk("a_ex_valid", 32'(ex_valid),     32'd1);
      chk("a_ex_dest",  32'(ex_dest),      32'd8);
      chk("a_ex_rw",    32'(ex_reg_write), 32'd1);
      chk("a_rs_byp",   ex_rs_data,        32'hDEADBEEF);
      chk("a_rt_rf",    ex_rt_data,        init_val(10));
      chk("a_funct",    32'(ex_funct),     32'h20);
      chk("a_issue_rd", 32'(rf_rd),        32'd0);

      // Stall in ISSUE, then writeback to rt tracks into the held operand.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("b_stall_valid", 32'(ex_valid), 32'd1);
         chk("b_stall_rt",    ex_rt_data,    init_val(10));
         chk("b_stall_pc",    ex_pc,         32'h200);
      end
      @(negedge clk);
      wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      chk("b_rt_track", ex_rt_data,    32'h55);
      chk("b_rs_keep",  ex_rs_data,    32'hDEADBEEF);
      chk("b_imm_keep", ex_imm,        32'h00004020);
      chk("b_valid",    32'(ex_valid), 32'd1);
      ex_ready = 1'b1;
      #1 chk("b_issue_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      ex_ready = 1'b0;
      #1;
      chk("b_after_xfer_valid", 32'(ex_valid), 32'd0);
      chk("b_after_xfer_ready", 32'(id_ready), 32'd1);

      // Flush during READ drops both held and incoming instructions.
      if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h240;
      @(negedge clk);
      flush = 1'b1; if_valid = 1'b1; if_instr = I_ORI; if_pc = 32'h244;
      #1 chk("c_read_rf_rd", 32'(rf_rd), 32'd1);
      @(negedge clk);
      flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
      #1;
      chk("c_flush_valid", 32'(ex_valid), 32'd0);
      chk("c_flush_rf_rd", 32'(rf_rd),    32'd0);
      chk("c_flush_ready", 32'(id_ready), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1 chk("c_dropped_valid", 32'(ex_valid), 32'd0);
      end

      // Back-to-back issue: override from the first must not leak into the second.
      if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h280;
      @(negedge clk);
      if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
      @(negedge clk);
      wb_we = 1'b0; if_valid = 1'b1; if_instr = I_ANDI; if_pc = 32'h284;
      #1;
      chk("d_first_rs",    ex_rs_data,    32'h77);
      chk("d_first_valid", 32'(ex_valid), 32'd1);
      chk("d_issue_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      chk("d_gap_valid", 32'(ex_valid),          32'd0);
      chk("d_gap_rf_rd", 32'(rf_rd),             32'd1);
      chk("d_gap_addr1", 32'(rf_read_address_1), 32'd4);
      @(negedge clk);
      #1;
      chk("d_second_valid", 32'(ex_valid), 32'd1);
      chk("d_second_rs",    ex_rs_data,    init_val(4));
      chk("d_second_rt",    ex_rt_data,    init_val(5));
      chk("d_second_imm",   ex_imm,        32'h0000F0F0);
      chk("d_second_pc",    ex_pc,         32'h284);

      // Enable low freezes READ and ISSUE.
      @(negedge clk);
      ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h2C0;
      @(negedge clk);
      if_valid = 1'b0; en = 1'b0;
      #1;
      chk("e_frz_rf_rd", 32'(rf_rd),    32'd0);
      chk("e_frz_ready", 32'(id_ready), 32'd0);
      @(negedge clk);
      en = 1'b1;
      #1 chk("e_resume_rf_rd", 32'(rf_rd), 32'd1);
      @(negedge clk);
      ex_ready = 1'b1; en = 1'b0;
      #1;
      chk("e_frz_issue_ready", 32'(id_ready), 32'd0);
      chk("e_frz_issue_valid", 32'(ex_valid), 32'd1);
      @(negedge clk);
      #1 chk("e_frz_hold_valid", 32'(ex_valid), 32'd1);
      en = 1'b1;
      @(negedge clk);
      ex_ready = 1'b0;
      #1 chk("e_done_valid", 32'(ex_valid), 32'd0);

      // Reset while issuing clears every output.
      if_valid = 1'b1; if_instr = I_SLTI; if_pc = 32'h300;
      @(negedge clk);
      if_valid = 1'b0;
      @(negedge clk);
      #1 chk("f_pre_valid", 32'(ex_valid), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("f_valid",  32'(ex_valid),     32'd0);
      chk("f_ready",  32'(id_ready),     32'd0);
      chk("f_rf_rd",  32'(rf_rd),        32'd0);
      chk("f_rs",     ex_rs_data,        32'd0);
      chk("f_rt",     ex_rt_data,        32'd0);
      chk("f_imm",    ex_imm,            32'd0);
      chk("f_pc",     ex_pc,             32'd0);
      chk("f_opcode", 32'(ex_opcode),    32'd0);
      chk("f_funct",  32'(ex_funct),     32'd0);
      chk("f_dest",   32'(ex_dest),      32'd0);
      chk("f_rw",     32'(ex_reg_write), 32'd0);
      rst = 1'b1;

      // Decode table through the scoreboard with random execute backpressure.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         e.instr = vecs[i].instr;
         e.pc    = 32'h1000 + 32'(i) * 4;
         e.imm   = vecs[i].imm;
         e.dest  = vecs[i].dest;
         e.rw    = vecs[i].rw;
         e.rs    = (vecs[i].instr[25:21] == 5'd0) ? 32'd0 : init_val(int'(vecs[i].instr[25:21]));
         e.rt    = (vecs[i].instr[20:16] == 5'd0) ? 32'd0 : init_val(int'(vecs[i].instr[20:16]));
         accepted = 0;
         for (int g = 0; g < 40 && accepted == 0; g++) begin
            @(negedge clk);
            if_valid = 1'b1; if_instr = e.instr; if_pc = e.pc;
            ex_ready = ($urandom_range(0, 3) != 0);
            #1;
            sb_pop();
            if (id_ready) begin
               sb_q.push_back(e);
               accepted = 1;
            end
         end
         chk("tbl_accepted", 32'(accepted), 32'd1);
      end
      for (int g = 0; g < 40 && sb_q.size() != 0; g++) begin
         @(negedge clk);
         if_valid = 1'b0;
         ex_ready = ($urandom_range(0, 3) != 0);
         #1;
         sb_pop();
      end
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
